// File: rtl/commit_feed_queue.sv
// In-order commit queue: slots allocate at tail, complete out of order via writeback, retire in order from head.
// Writeback-to-commit latency 1 cycle; issue_ready_o drops while all NR_ENTRIES slots are occupied.
module commit_feed_queue #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DATA_W          = 64,
  localparam int unsigned TID_W          = $clog2(NR_ENTRIES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic                                    issue_valid_i,
  output logic                                    issue_ready_o,
  input  logic [63:0]                             issue_pc_i,
  input  logic [4:0]                              issue_rd_i,
  input  logic [3:0]                              issue_fu_i,
  output logic [TID_W-1:0]                        issue_trans_id_o,
  input  logic                                    wb_valid_i,
  input  logic [TID_W-1:0]                        wb_trans_id_i,
  input  logic [DATA_W-1:0]                       wb_result_i,
  input  logic                                    wb_ex_valid_i,
  output logic [NR_COMMIT_PORTS-1:0]              commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0]        commit_pc_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]         commit_rd_o,
  output logic [NR_COMMIT_PORTS-1:0][3:0]         commit_fu_o,
  output logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]  commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]              commit_ex_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][TID_W-1:0]   commit_trans_id_o,
  input  logic [NR_COMMIT_PORTS-1:0]              commit_ack_i,
  output logic [TID_W:0]                          count_o
);

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [3:0]  fu;
  } hdr_t;

  logic [NR_ENTRIES-1:0]              occ_q, done_q, ex_q;
  hdr_t [NR_ENTRIES-1:0]              hdr_q;
  logic [NR_ENTRIES-1:0][DATA_W-1:0]  result_q;
  logic [TID_W-1:0]                   head_q, tail_q;
  logic [TID_W:0]                     count_q;

  logic                                  issue_fire, wb_fire;
  logic [NR_COMMIT_PORTS-1:0]            retire;
  logic [NR_COMMIT_PORTS-1:0][TID_W-1:0] port_idx;
  logic [TID_W:0]                        n_retire;

  assign count_o          = count_q;
  assign issue_ready_o    = count_q < (TID_W+1)'(NR_ENTRIES);
  assign issue_trans_id_o = tail_q;
  assign issue_fire       = issue_valid_i && issue_ready_o && !flush_i;
  assign wb_fire          = wb_valid_i && occ_q[wb_trans_id_i] && !done_q[wb_trans_id_i] && !flush_i;

  always_comb begin
    port_idx          = '0;
    commit_valid_o    = '0;
    commit_pc_o       = '0;
    commit_rd_o       = '0;
    commit_fu_o       = '0;
    commit_result_o   = '0;
    commit_ex_valid_o = '0;
    commit_trans_id_o = '0;
    retire            = '0;
    n_retire          = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      port_idx[p]          = head_q + TID_W'(p);
      commit_valid_o[p]    = occ_q[port_idx[p]] && done_q[port_idx[p]];
      commit_pc_o[p]       = hdr_q[port_idx[p]].pc;
      commit_rd_o[p]       = hdr_q[port_idx[p]].rd;
      commit_fu_o[p]       = hdr_q[port_idx[p]].fu;
      commit_result_o[p]   = result_q[port_idx[p]];
      commit_ex_valid_o[p] = ex_q[port_idx[p]];
      commit_trans_id_o[p] = port_idx[p];
    end
    // A younger port only retires alongside every older port.
    retire[0] = commit_ack_i[0] && commit_valid_o[0] && !flush_i;
    for (int p = 1; p < NR_COMMIT_PORTS; p++)
      retire[p] = retire[p-1] && commit_ack_i[p] && commit_valid_o[p];
    for (int p = 0; p < NR_COMMIT_PORTS; p++)
      n_retire = n_retire + (TID_W+1)'(retire[p]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      occ_q   <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (issue_fire) begin
        occ_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= 1'b0;
        ex_q[tail_q]   <= 1'b0;
        tail_q         <= tail_q + TID_W'(1);
      end
      if (wb_fire) begin
        done_q[wb_trans_id_i] <= 1'b1;
        ex_q[wb_trans_id_i]   <= wb_ex_valid_i;
      end
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (retire[p]) begin
          occ_q[port_idx[p]]  <= 1'b0;
          done_q[port_idx[p]] <= 1'b0;
        end
      end
      head_q  <= head_q + n_retire[TID_W-1:0];
      count_q <= count_q + (TID_W+1)'(issue_fire) - n_retire;
    end
  end

  // Payload is qualified by occ/done, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (issue_fire)
      hdr_q[tail_q] <= hdr_t'{pc: issue_pc_i, rd: issue_rd_i, fu: issue_fu_i};
    if (wb_fire)
      result_q[wb_trans_id_i] <= wb_result_i;
  end

endmodule

// File: doc/commit_feed_queue.md
COMMIT_FEED_QUEUE -- requirements
Module: commit_feed_queue

Interface
REQ-001 Parameter NR_ENTRIES, default 8, SHALL set queue depth (power of two, minimum 4).
REQ-002 Parameter NR_COMMIT_PORTS, default 2, SHALL set the number of commit ports presented (1 or 2).
REQ-003 Parameter DATA_W, default 64, SHALL set result width; TID_W = log2(NR_ENTRIES).
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  discard all entries.
REQ-007 issue_valid_i  in  1  new instruction to allocate.
REQ-008 issue_ready_o  out  1  queue can accept an allocation.
REQ-009 issue_pc_i  in  64  instruction PC.
REQ-010 issue_rd_i  in  5  destination register.
REQ-011 issue_fu_i  in  4  functional-unit code.
REQ-012 issue_trans_id_o  out  TID_W  slot index given to the current allocation.
REQ-013 wb_valid_i  in  1  writeback strobe.
REQ-014 wb_trans_id_i  in  TID_W  slot being written back.
REQ-015 wb_result_i  in  DATA_W  result data.
REQ-016 wb_ex_valid_i  in  1  writeback carries an exception.
REQ-017 commit_valid_o  out  NR_COMMIT_PORTS  port i holds a finished entry.
REQ-018 commit_pc_o / commit_rd_o / commit_fu_o / commit_result_o / commit_ex_valid_o / commit_trans_id_o  out  NR_COMMIT_PORTS x (64/5/4/DATA_W/1/TID_W)  per-port entry fields.
REQ-019 commit_ack_i  in  NR_COMMIT_PORTS  commit stage retires port i this cycle.
REQ-020 count_o  out  TID_W+1  occupied entries.

Function
REQ-021 Storage SHALL be a circular buffer with head (oldest) and tail (next free) pointers, TID_W bits each, wrapping modulo NR_ENTRIES.
REQ-022 issue_ready_o SHALL be 1 iff count_o < NR_ENTRIES, using the registered count only (no same-cycle bypass from retirement).
REQ-023 issue_trans_id_o SHALL equal tail combinationally.
REQ-024 On issue_valid_i && issue_ready_o the slot at tail SHALL be marked occupied, not done, ex cleared, and pc/rd/fu captured; tail increments by 1.
REQ-025 On wb_valid_i to an occupied, not-done slot, the slot SHALL capture result and ex and become done at the next edge; writebacks to unoccupied or already-done slots SHALL be ignored.
REQ-026 Port i SHALL present the slot at head+i; commit_valid_o[i] = occupied && done for that slot; all fields SHALL come from registers (writeback-to-commit latency 1 cycle).
REQ-027 Retirement count n: n=1 if commit_ack_i[0] && commit_valid_o[0]; n=2 if additionally commit_ack_i[1] && commit_valid_o[1]; ack[1] without a valid ack[0] SHALL be ignored; ack on an invalid port SHALL be ignored.
REQ-028 Retired slots SHALL be cleared (occupied=0, done=0); head advances by n.
REQ-029 Issue, writeback and retirement in one cycle SHALL all take effect; count_next = count + issue - n.
REQ-030 flush_i SHALL take priority over issue, writeback and ack in that cycle: all occupied/done bits cleared, head=tail=0, count_o=0 next cycle; issue_ready_o SHALL still reflect the pre-flush count during the flush cycle, but no allocation occurs.
REQ-031 When NR_COMMIT_PORTS=1, only port 0 SHALL exist and n is at most 1.

Reset
REQ-032 On rst_ni low, asynchronously: head=0, tail=0, count_o=0, all occupied/done/ex bits 0, commit_valid_o=0, issue_ready_o=1 after release; payload registers need not be reset.
REQ-033 Reset asserted mid-operation SHALL discard all entries identically to power-on reset.

Verification
REQ-034 Issue 3 (pc 0x80000000/4/8), no writeback -> trans_ids 0,1,2; count_o=3; commit_valid_o=00.
REQ-035 Writeback tid 1 then tid 0 (results 0xA,0xB) -> commit_valid_o=11 one cycle after tid 0 writeback, port0 result 0xB, port1 0xA; ack=11 -> count_o=1, head=2.
REQ-036 Fill 8 entries -> issue_ready_o=0; retire 2 while issuing -> no allocation that cycle; next cycle issue_ready_o=1, allocated tid=0 (wrap-around).
REQ-037 commit_ack_i=10 with both ports valid -> only head retired; commit_ack_i=10 with port0 invalid -> nothing retired.
REQ-038 flush_i with 5 entries, simultaneous issue and writeback -> count_o=0 next cycle, next allocation tid 0, stale writeback to tid 2 after flush ignored.
REQ-039 rst_ni pulsed low between clock edges with 4 entries -> outputs reach reset values immediately, commit_valid_o=00.
